// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program-memory loader.
package prog_loader_pkg;

  localparam int DEF_ADDR_W    = 11;
  localparam int DEF_DATA_W    = 14;
  localparam int DEF_MAX_WORDS = 2048;

  localparam logic [7:0] HI_MASK     = 8'hC0;
  localparam logic [7:0] CNT_HI_MASK = 8'hF0;

  typedef enum logic [3:0] {
    IDLE,
    CNT_HI,
    CNT_LO,
    W_HI,
    W_LO,
    WRITE,
    CHK,
    DONE,
    ERROR
  } state_t;

endpackage

// File: rtl/prog_loader.sv
// Framed byte-stream loader: packs HI/LO byte pairs into instruction words and
// writes them sequentially into program memory while holding the CPU in reset.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_WORDS = DEF_MAX_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              prog_we,
  output logic [ADDR_W-1:0] prog_addr,
  output logic [DATA_W-1:0] prog_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [12:0] MAX_CNT = 13'(MAX_WORDS);

  state_t              state_q, state_d;
  logic [7:0]          cnt_hi_q, cnt_hi_d;
  logic [11:0]         count_q, count_d;
  logic [11:0]         widx_q, widx_d;
  logic [5:0]          hi_q, hi_d;
  logic [7:0]          sum_q, sum_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  logic        accept;
  logic [11:0] n_word;

  assign n_word = {cnt_hi_q[3:0], rx_data};
  assign accept = rx_valid && rx_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_hi_q <= '0;
      count_q  <= '0;
      widx_q   <= '0;
      hi_q     <= '0;
      sum_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_hi_q <= cnt_hi_d;
      count_q  <= count_d;
      widx_q   <= widx_d;
      hi_q     <= hi_d;
      sum_q    <= sum_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_hi_d = cnt_hi_q;
    count_d  = count_q;
    widx_d   = widx_q;
    hi_d     = hi_q;
    sum_d    = sum_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;

    rx_ready = 1'b0;
    prog_we  = 1'b0;

    unique case (state_q)
      IDLE, ERROR: begin
        if (start) begin
          state_d = CNT_HI;
          widx_d  = '0;
          sum_d   = '0;
        end
      end
      CNT_HI: begin
        rx_ready = 1'b1;
        if (accept) begin
          cnt_hi_d = rx_data;
          state_d  = CNT_LO;
        end
      end
      CNT_LO: begin
        rx_ready = 1'b1;
        if (accept) begin
          count_d = n_word;
          if (((cnt_hi_q & CNT_HI_MASK) == 8'h00) && (n_word != 12'd0) &&
              ({1'b0, n_word} <= MAX_CNT))
            state_d = W_HI;
          else
            state_d = ERROR;
        end
      end
      W_HI: begin
        rx_ready = 1'b1;
        if (accept) begin
          if ((rx_data & HI_MASK) == 8'h00) begin
            hi_d    = rx_data[5:0];
            sum_d   = sum_q + rx_data;
            state_d = W_LO;
          end else begin
            state_d = ERROR;
          end
        end
      end
      W_LO: begin
        rx_ready = 1'b1;
        if (accept) begin
          // Latch address and data now so they hold after the WRITE cycle.
          wdata_d = DATA_W'({hi_q, rx_data});
          addr_d  = widx_q[ADDR_W-1:0];
          sum_d   = sum_q + rx_data;
          state_d = WRITE;
        end
      end
      WRITE: begin
        prog_we = 1'b1;
        widx_d  = widx_q + 12'd1;
        if (widx_q + 12'd1 == count_q)
          state_d = CHK;
        else
          state_d = W_HI;
      end
      CHK: begin
        rx_ready = 1'b1;
        if (accept)
          state_d = (rx_data == sum_q) ? DONE : ERROR;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign prog_addr  = addr_q;
  assign prog_wdata = wdata_q;
  assign cpu_rst    = (state_q != IDLE);
  assign busy       = (state_q != IDLE) && (state_q != ERROR);
  assign done       = (state_q == DONE);
  assign err        = (state_q == ERROR);

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected writes are queued by the stimulus
// thread and compared by an independent monitor on every prog_we cycle.
module tb_prog_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        prog_we;
  logic [10:0] prog_addr;
  logic [13:0] prog_wdata;
  logic        cpu_rst;
  logic        busy;
  logic        done;
  logic        err;

  int checks   = 0;
  int failures = 0;
  int done_seen = 0;

  typedef struct packed {
    logic [10:0] addr;
    logic [13:0] data;
  } wr_t;

  wr_t exp_q[$];

  prog_loader dut (
    .clk(clk), .rst(rst), .start(start),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
    .cpu_rst(cpu_rst), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: pops one expectation per write strobe, counts done pulses.
  initial begin
    forever begin
      @(negedge clk);
      if (done === 1'b1) done_seen++;
      if (prog_we === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write",
                   prog_addr, prog_wdata);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          if (prog_addr !== e.addr || prog_wdata !== e.data) begin
            failures++;
            $display("FAIL write: got addr 0x%0h data 0x%0h expected addr 0x%0h data 0x%0h",
                     prog_addr, prog_wdata, e.addr, e.data);
          end
        end
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int waits;
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    waits    = 0;
    while (rx_ready !== 1'b1 && waits < 100) begin
      @(negedge clk);
      waits++;
    end
    if (rx_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL rx_ready_timeout: got rx_ready 0 expected 1 within 100 cycles");
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic push_word(input logic [10:0] a, input logic [13:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  logic [7:0] good_frame [7] = '{8'h00, 8'h02, 8'h30, 8'h55, 8'h3E, 8'h01, 8'hC4};

  initial begin
    int d0;
    logic [7:0]  sum;
    logic [13:0] w;
    rst = 1'b1; start = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_rx_ready", {31'd0, rx_ready}, 32'd0);
    check("reset_busy",     {31'd0, busy},     32'd0);
    check("reset_cpu_rst",  {31'd0, cpu_rst},  32'd0);
    check("reset_err",      {31'd0, err},      32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Good load
    push_word(11'd0, 14'h3055);
    push_word(11'd1, 14'h3E01);
    d0 = done_seen;
    pulse_start();
    check("start_cpu_rst", {31'd0, cpu_rst},  32'd1);
    check("start_busy",    {31'd0, busy},     32'd1);
    for (int i = 0; i < 7; i++) send_byte(good_frame[i], 0);
    check("good_done_now", {31'd0, done},     32'd1);
    check("good_cpu_rst_in_done", {31'd0, cpu_rst}, 32'd1);
    @(negedge clk);
    check("good_cpu_rst_after", {31'd0, cpu_rst}, 32'd0);
    check("good_done_count", done_seen - d0, 32'd1);
    check("good_err",        {31'd0, err},      32'd0);
    check("good_queue_empty", exp_q.size(), 32'd0);

    // Bad checksum
    push_word(11'd0, 14'h3055);
    push_word(11'd1, 14'h3E01);
    d0 = done_seen;
    pulse_start();
    for (int i = 0; i < 6; i++) send_byte(good_frame[i], 1);
    send_byte(8'hC5, 0);
    @(negedge clk);
    check("badchk_err",     {31'd0, err},     32'd1);
    check("badchk_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("badchk_busy",    {31'd0, busy},    32'd0);
    check("badchk_no_done", done_seen - d0,   32'd0);
    check("badchk_queue_empty", exp_q.size(), 32'd0);
    pulse_start();
    check("badchk_err_cleared", {31'd0, err}, 32'd0);

    // Header errors (first session already started above)
    send_byte(8'h00, 0); send_byte(8'h00, 0);
    check("hdr_zero_err", {31'd0, err}, 32'd1);
    pulse_start();
    send_byte(8'h08, 0); send_byte(8'h01, 0);
    check("hdr_big_err", {31'd0, err}, 32'd1);
    pulse_start();
    send_byte(8'h10, 0); send_byte(8'h01, 0);
    check("hdr_upper_err", {31'd0, err}, 32'd1);

    // Illegal HI byte
    pulse_start();
    send_byte(8'h00, 0); send_byte(8'h01, 0); send_byte(8'h40, 0);
    check("hi_illegal_err", {31'd0, err}, 32'd1);
    @(negedge clk);
    check("hi_illegal_busy", {31'd0, busy}, 32'd0);

    // Reset mid-word: no partial word may be written
    pulse_start();
    send_byte(8'h00, 0); send_byte(8'h01, 0); send_byte(8'h12, 0);
    #1 rst = 1'b1;
    #1;
    check("midrst_rx_ready", {31'd0, rx_ready}, 32'd0);
    check("midrst_cpu_rst",  {31'd0, cpu_rst},  32'd0);
    check("midrst_busy",     {31'd0, busy},     32'd0);
    check("midrst_addr",     {21'd0, prog_addr}, 32'd0);
    check("midrst_wdata",    {18'd0, prog_wdata}, 32'd0);
    check("midrst_err",      {31'd0, err},      32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("postrst_cpu_rst", {31'd0, cpu_rst}, 32'd0);
    check("postrst_ready",   {31'd0, rx_ready}, 32'd0);

    // Full 2048-word load with random gaps and an ignored start
    d0 = done_seen;
    sum = 8'h00;
    pulse_start();
    send_byte(8'h08, 0); send_byte(8'h00, 0);
    for (int i = 0; i < 2048; i++) begin
      w = 14'($urandom);
      push_word(11'(i), w);
      sum = sum + {2'b00, w[13:8]} + w[7:0];
      send_byte({2'b00, w[13:8]}, $urandom_range(0, 2));
      send_byte(w[7:0], $urandom_range(0, 2));
      if (i == 1000) pulse_start();
    end
    send_byte(sum, 1);
    repeat (2) @(negedge clk);
    check("big_done_count", done_seen - d0, 32'd1);
    check("big_err",        {31'd0, err},   32'd0);
    check("big_queue_empty", exp_q.size(), 32'd0);
    check("big_last_addr",  {21'd0, prog_addr}, 32'h7FF);
    check("big_cpu_rst_after", {31'd0, cpu_rst}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
